// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: computes a - b LSB first, one bit per clock,
// through a single full-subtractor cell and a 1-bit borrow register.
// The minuend shift register doubles as the result register: each cycle the
// consumed LSB leaves at the bottom and the new difference bit enters at the top.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    // Wide enough to hold WIDTH itself, so the final increment never wraps.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               br_q, br_d;
    logic               bout_q, bout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               diff_bit;
    logic               br_next;

    // Full-subtractor cell acting on the current LSBs and the stored borrow.
    always_comb begin
        diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_next  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    end

    // Next-state and datapath control for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end
            end

            SHIFT: begin
                a_sh_d = {diff_bit, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last bit: publish the whole difference at once so d never
                    // shows a partially shifted value.
                    state_d = DONE;
                    d_d     = {diff_bit, a_sh_q[WIDTH-1:1]};
                    bout_d  = br_next;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all flops updating from the same
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8). Expected results are queued
// when an operation is launched and popped when the DUT raises done.
// Inputs are driven and outputs sampled on the falling edge.
module tb_serial_sub;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        e.d    = W'(av - bv);
        e.bout = (av < bv);
        return e;
    endfunction

    // One full transaction. The edge right after start is driven is edge 1
    // (the accepting edge); done must appear after edge W+1 with busy seen
    // for exactly W sampled cycles. With perturb set, start is pulsed again
    // and the operands change three cycles into SHIFT.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit perturb);
        exp_t e;
        int   lat      = 0;
        int   busy_cnt = 0;
        bit   seen     = 0;
        sb.push_back(model(av, bv));
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        for (int k = 1; k <= 30 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (perturb && k == 3) begin
                start = 1'b1;
                a     = ~av;
                b     = W'($urandom);
            end
            if (done) begin
                seen = 1;
                lat  = k;
            end else if (busy) begin
                busy_cnt++;
            end
        end
        start = 1'b0;
        check("latency", lat, W + 1);
        check("busy_cycles", busy_cnt, W);
        e = sb.pop_front();
        check("d", d, e.d);
        check("bout", bout, e.bout);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        int   n_done;
        int   pulse_t[$];
        exp_t e;

        rst   = 1'b1;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_d", d, 8'h00);
        check("rst_bout", bout, 1'b0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("idle_no_start_busy", busy, 1'b0);

        // Directed operand patterns, including borrow and all-ones cases.
        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h03, 8'h05, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0);

        // Start and operands disturbed mid-operation: result unchanged and no
        // second done afterwards.
        run_op(8'h5A, 8'h3C, 1'b1);
        n_done = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("no_second_done", n_done, 0);

        // Reset during SHIFT bit 4 aborts the operation.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h77;
        b     = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_d", d, 8'h00);
        check("abort_bout", bout, 1'b0);
        n_done = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_op(8'h77, 8'h11, 1'b0);
        run_op(8'h10, 8'h20, 1'b0);

        // Back-to-back with start held high: one result every W+2 cycles.
        for (int i = 0; i < 4; i++) sb.push_back(model(8'hC3, 8'hD4));
        @(negedge clk);
        start = 1'b1;
        a     = 8'hC3;
        b     = 8'hD4;
        for (int t = 1; t <= 80 && pulse_t.size() < 4; t++) begin
            @(negedge clk);
            if (done) begin
                pulse_t.push_back(t);
                if (pulse_t.size() == 4) start = 1'b0;
                e = sb.pop_front();
                check("b2b_d", d, e.d);
                check("b2b_bout", bout, e.bout);
            end
        end
        start = 1'b0;
        check("b2b_pulses", pulse_t.size(), 4);
        for (int i = 1; i < pulse_t.size(); i++)
            check("b2b_spacing", pulse_t[i] - pulse_t[i-1], W + 2);
        sb.delete();
        repeat (W + 3) @(negedge clk);
        check("b2b_idle", busy, 1'b0);

        // Random sweep with latency checked on every transaction.
        for (int i = 0; i < 1000; i++)
            run_op(W'($urandom), W'($urandom), 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
